w5300_bus_arbiter: RTL

- Shares the single W5300 register-access engine among N requesters: IRQ handler, socket TX/RX sequencers, init/config.
- Each requester presents an 11-bit command word {RD/WR flag, 10-bit register address} plus 16-bit write data, and waits for an ack.
- The arbiter serialises these commands onto the access engine, one at a time, and returns read data.
- Sits between the protocol-level blocks and the W5300 bus-timing engine.

---
 rtl/w5300_bus_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/w5300_bus_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : w5300_bus_arbiter
// Purpose  : Serialises register-access commands from N_REQ requesters onto the
//            single W5300 bus-timing engine (strict-priority IRQ slot optional,
//            round-robin otherwise). Optional bus_done watchdog enabled by the
//            W5300_ARB_TIMEOUT_EN macro.
// Revision : 1.0 - initial release
// =============================================================================
module w5300_bus_arbiter #(
    parameter int N_REQ          = 4,
    parameter bit PRIO0          = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ*11-1:0]   i_req_cmd,
    input  logic [N_REQ*16-1:0]   i_req_wr_data,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_ack,
    output logic                  o_err,
    output logic [15:0]           o_rd_data,
    output logic                  o_bus_start,
    output logic [10:0]           o_bus_cmd,
    output logic [15:0]           o_bus_wr_data,
    input  logic [15:0]           i_bus_rd_data,
    input  logic                  i_bus_done
);

    localparam int          c_PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Parking command: a read of an unused register address
    localparam logic [10:0] c_IDLE_CMD = {1'b1, 10'h3fe};
    localparam logic [15:0] c_TMO_DATA = 16'hdead;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("w5300_bus_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_REQ-1:0]     r_gnt;
    logic [c_PTR_W-1:0]   r_owner;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic                 r_prio_win;
    logic [10:0]          r_bus_cmd;
    logic [15:0]          r_bus_wr_data;
    logic [15:0]          r_rd_data;
    logic                 w_any_req;
    logic                 w_prio_hit;
    logic [c_PTR_W-1:0]   w_win;
    logic                 w_bus_start;
    logic [N_REQ-1:0]     w_ack;
    logic                 w_expire;

    function automatic logic [c_PTR_W-1:0] f_wrap_add(input logic [c_PTR_W-1:0] base,
                                                      input int                 off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return c_PTR_W'(sum);
    endfunction

    // Scan downward so the last hit is the first set bit at or after rr_ptr
    always_comb begin
        w_any_req  = |i_req;
        w_prio_hit = PRIO0 && i_req[0];
        w_win      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[f_wrap_add(r_rr_ptr, i)]) begin
                w_win = f_wrap_add(r_rr_ptr, i);
            end
        end
        if (w_prio_hit) begin
            w_win = '0;
        end
    end

`ifdef W5300_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_expire = (r_state == S_WAIT) && (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

    // A bus_done coinciding with expiry is a real completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == S_WAIT && !i_bus_done && w_expire) begin
            r_err <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_err <= 1'b0;
        end
    end

    assign o_err = r_err;
`else
    assign w_expire = 1'b0;
    assign o_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bus_start = 1'b0;
        w_ack       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_bus_start = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_bus_done || w_expire) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_ack       = r_gnt;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt         <= '0;
            r_owner       <= '0;
            r_prio_win    <= 1'b0;
            r_rr_ptr      <= '0;
            r_bus_cmd     <= c_IDLE_CMD;
            r_bus_wr_data <= '0;
            r_rd_data     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt         <= N_REQ'(1) << w_win;
                        r_owner       <= w_win;
                        r_prio_win    <= w_prio_hit;
                        r_bus_cmd     <= i_req_cmd[11*w_win +: 11];
                        r_bus_wr_data <= i_req_wr_data[16*w_win +: 16];
                    end
                end
                S_WAIT: begin
                    if (i_bus_done) begin
                        r_rd_data <= i_bus_rd_data;
                    end else if (w_expire) begin
                        r_rd_data <= c_TMO_DATA;
                    end
                end
                S_DONE: begin
                    r_gnt         <= '0;
                    r_bus_cmd     <= c_IDLE_CMD;
                    r_bus_wr_data <= '0;
                    // A priority grant to requester 0 leaves the rotation untouched
                    if (!r_prio_win) begin
                        r_rr_ptr <= f_wrap_add(r_owner, 1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_gnt         = r_gnt;
    assign o_ack         = w_ack;
    assign o_rd_data     = r_rd_data;
    assign o_bus_start   = w_bus_start;
    assign o_bus_cmd     = r_bus_cmd;
    assign o_bus_wr_data = r_bus_wr_data;

endmodule
`default_nettype wire
